execute_pipe: RTL
=================

EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath and register width.
REQ-002 SHALL have parameter NREG, default 32: register count; RA = clog2(NREG) address bits taken from the low bits of each 5-bit instruction field.
REQ-003 SHALL have parameter FWD_EN, default 1: 1 = WB-to-EX forwarding, 0 = in_ready drops for one cycle on a RAW hazard.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port list:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  synchronous active-high reset.
- in_valid  in  1  instr is presented.
- in_ready  out  1  instr accepted this cycle when in_valid & in_ready.
- instr  in  32  MIPS R/I-type word.
- stall  in  1  freezes the whole pipeline.
- busA  out  XLEN  operand A (rs) after forwarding, registered in EX.
- busB  out  XLEN  operand B (rt or immediate), registered in EX.
- busW  out  XLEN  WB-stage result.
- wb_valid  out  1  WB stage holds a committing result.
- wb_reg  out  RA  WB destination.
- ovf  out  1  one-cycle signed-overflow pulse.
- illegal  out  1  one-cycle unsupported-op pulse.
- dbg_sel  in  RA  debug register select.
- dbg_data  out  XLEN  committed register[dbg_sel], combinational.

Function
REQ-006 SHALL support these R-type functs (op 0x00): sll 00, srl 02, sra 03, add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B. Destination is rd; shift amount is shamt.
REQ-007 SHALL support these I-type ops: addi 08, addiu 09, slti 0A, andi 0C, ori 0D, xori 0E, lui 0F. Destination is rt; addi/addiu/slti sign-extend imm; andi/ori/xori zero-extend; lui = imm<<16 (truncated when XLEN<32).
REQ-008 SHALL implement a two-stage pipeline:
- EX: on accept, decode, read rs/rt, compute, and register result/dest/valid.
- WB: write the register file on the next unstalled edge.
REQ-009 Latency: an instr accepted at edge N SHALL show busW/wb_valid after edge N and be committed at edge N+1.
REQ-010 With FWD_EN=1, an EX read of the register pending in WB SHALL return the WB value; in_ready = ~stall.
REQ-011 With FWD_EN=0, on a RAW hazard with WB, in_ready SHALL be 0 for that cycle and the instr SHALL be accepted the cycle after.
REQ-012 Register 0 SHALL read zero; writes to it SHALL be discarded, with wb_valid=0.
REQ-013 On add/sub/addi signed overflow, there SHALL be no write, ovf pulses with WB timing, and wb_valid=0.
REQ-014 On an unsupported op/funct, illegal SHALL pulse with WB timing, with no write and wb_valid=0.
REQ-015 Arithmetic SHALL wrap modulo 2^XLEN. slt/sltu/slti SHALL produce 0 or 1 zero-extended.
REQ-016 While stall=1:
- no accept;
- EX and WB registers held;
- no write;
- ovf/illegal not re-pulsed.
REQ-017 A cycle with no accept (in_valid=0 or in_ready=0) SHALL insert a bubble into EX.

Reset
REQ-018 Under RST, SHALL clear all registers, EX/WB state, busA, busB, busW, wb_reg, ovf and illegal to 0, with wb_valid=0 and in_ready=0.
REQ-019 RST during a pending WB SHALL drop the write; RST SHALL take priority over stall.

Structure
REQ-020 SHALL place in package execute_pkg: opcode and funct constants, the ALU-op enum, and the decoded-control struct.
REQ-021 SHALL instantiate one sub-module, exec_alu: combinational XLEN ALU returning result and ovf.
REQ-022 The register file SHALL be an inline array in execute_pipe.

Verification
REQ-023 Reset, then instr 0x00010820 (add $1,$0,$1) -> busW=0, wb_reg=1, dbg reg1=0.
REQ-024 addi $1,$0,5 then add $2,$1,$1 back-to-back (FWD_EN=1) -> busW=10, reg2=10, no bubble. With FWD_EN=0 -> one in_ready=0 cycle, same final values.
REQ-025 lui $4,0x7FFF then add $5,$4,$4 -> ovf pulse, reg5=0. addu $6,$4,$4 -> reg6=0xFFFE0000.
REQ-026 addi $0,$0,7 -> wb_valid=0, reg0=0. Opcode 0x3F -> illegal pulse, no register change.
REQ-027 stall=1 for 3 cycles with in_valid=1 and ori $7,$0,0x00FF in EX -> in_ready=0, busW held, single commit after release, reg7=0x000000FF.
REQ-028 RST asserted the cycle addi $8,$0,9 sits in WB -> reg8=0, wb_valid=0 next cycle.

Source files
------------

// File: rtl/execute_pkg.sv
// Shared decode definitions for the two-stage MIPS-subset execute pipe:
// opcode/funct constants, ALU operation enum, decoded control word.
package execute_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
  } alu_op_e;

  typedef enum logic [1:0] {IMM_NONE, IMM_SEXT, IMM_ZEXT, IMM_LUI} imm_e;

  typedef struct packed {
    alu_op_e alu_op;
    imm_e    imm_kind;
    logic    dst_rt;
    logic    use_rs;
    logic    use_rt;
    logic    chk_ovf;
    logic    illegal;
  } ctrl_t;

  // Pure decode of one instruction word; use_rs/use_rt mark true source reads.
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    c.alu_op = ALU_ADD;
    c.use_rs = 1'b1;
    c.use_rt = 1'b1;
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          FN_SLL:  begin c.alu_op = ALU_SLL; c.use_rs = 1'b0; end
          FN_SRL:  begin c.alu_op = ALU_SRL; c.use_rs = 1'b0; end
          FN_SRA:  begin c.alu_op = ALU_SRA; c.use_rs = 1'b0; end
          FN_ADD:  begin c.alu_op = ALU_ADD; c.chk_ovf = 1'b1; end
          FN_ADDU: c.alu_op = ALU_ADD;
          FN_SUB:  begin c.alu_op = ALU_SUB; c.chk_ovf = 1'b1; end
          FN_SUBU: c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_XOR:  c.alu_op = ALU_XOR;
          FN_NOR:  c.alu_op = ALU_NOR;
          FN_SLT:  c.alu_op = ALU_SLT;
          FN_SLTU: c.alu_op = ALU_SLTU;
          default: c.illegal = 1'b1;
        endcase
      end
      OP_ADDI:  begin c.alu_op = ALU_ADD;   c.imm_kind = IMM_SEXT; c.chk_ovf = 1'b1; end
      OP_ADDIU: begin c.alu_op = ALU_ADD;   c.imm_kind = IMM_SEXT; end
      OP_SLTI:  begin c.alu_op = ALU_SLT;   c.imm_kind = IMM_SEXT; end
      OP_ANDI:  begin c.alu_op = ALU_AND;   c.imm_kind = IMM_ZEXT; end
      OP_ORI:   begin c.alu_op = ALU_OR;    c.imm_kind = IMM_ZEXT; end
      OP_XORI:  begin c.alu_op = ALU_XOR;   c.imm_kind = IMM_ZEXT; end
      OP_LUI:   begin c.alu_op = ALU_PASSB; c.imm_kind = IMM_LUI; c.use_rs = 1'b0; end
      default:  c.illegal = 1'b1;
    endcase
    if (instr[31:26] != OP_RTYPE) begin
      c.dst_rt = 1'b1;
      c.use_rt = 1'b0;
    end
    if (c.illegal) begin
      c.use_rs = 1'b0;
      c.use_rt = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational XLEN-wide ALU; shifts act on operand B, overflow flag is
// valid only for ALU_ADD / ALU_SUB.
module exec_alu
  import execute_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_e          i_op,
  input  logic [XLEN-1:0]  i_a,
  input  logic [XLEN-1:0]  i_b,
  input  logic [4:0]       i_shamt,
  output logic [XLEN-1:0]  o_result_c,
  output logic             o_ovf_c
);

  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

  always_comb begin
    o_result_c = '0;
    o_ovf_c    = 1'b0;
    case (i_op)
      ALU_ADD: begin
        o_result_c = w_sum;
        o_ovf_c    = (i_a[XLEN-1] == i_b[XLEN-1]) && (w_sum[XLEN-1] != i_a[XLEN-1]);
      end
      ALU_SUB: begin
        o_result_c = w_diff;
        o_ovf_c    = (i_a[XLEN-1] != i_b[XLEN-1]) && (w_diff[XLEN-1] != i_a[XLEN-1]);
      end
      ALU_AND:   o_result_c = i_a & i_b;
      ALU_OR:    o_result_c = i_a | i_b;
      ALU_XOR:   o_result_c = i_a ^ i_b;
      ALU_NOR:   o_result_c = ~(i_a | i_b);
      ALU_SLT:   o_result_c = XLEN'($signed(i_a) < $signed(i_b));
      ALU_SLTU:  o_result_c = XLEN'(i_a < i_b);
      ALU_SLL:   o_result_c = i_b << i_shamt;
      ALU_SRL:   o_result_c = i_b >> i_shamt;
      ALU_SRA:   o_result_c = XLEN'($signed(i_b) >>> i_shamt);
      ALU_PASSB: o_result_c = i_b;
      default:   o_result_c = '0;
    endcase
  end

endmodule

// File: rtl/execute_pipe.sv
// Two-stage (EX -> WB) MIPS-subset integer pipe with inline register file,
// optional WB-to-EX forwarding, and a global stall.
module execute_pipe
  import execute_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter bit          FWD_EN = 1'b1,
  localparam int unsigned RA    = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            stall,
  output logic [XLEN-1:0] busA,
  output logic [XLEN-1:0] busB,
  output logic [XLEN-1:0] busW,
  output logic            wb_valid,
  output logic [RA-1:0]   wb_reg,
  output logic            ovf,
  output logic            illegal,
  input  logic [RA-1:0]   dbg_sel,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] r_rf [NREG];
  logic [XLEN-1:0] r_busA, r_busB, r_busW;
  logic [RA-1:0]   r_wb_reg;
  logic            r_wb_valid, r_ovf, r_illegal;

  ctrl_t           w_ctrl;
  logic [RA-1:0]   w_rs, w_rt, w_rd, w_dst;
  logic [15:0]     w_imm;
  logic [XLEN-1:0] w_imm_ext, w_rs_val, w_rt_val, w_opb;
  logic [XLEN-1:0] w_alu_res;
  logic            w_alu_ovf, w_ovf, w_commit, w_hazard, w_accept;

  assign w_ctrl = decode(instr);
  assign w_rs   = instr[21 +: RA];
  assign w_rt   = instr[16 +: RA];
  assign w_rd   = instr[11 +: RA];
  assign w_imm  = instr[15:0];
  assign w_dst  = w_ctrl.dst_rt ? w_rt : w_rd;

  // WB never holds a valid write to r0, so r0 is never forwarded.
  assign w_rs_val = (FWD_EN && r_wb_valid && r_wb_reg == w_rs) ? r_busW : r_rf[w_rs];
  assign w_rt_val = (FWD_EN && r_wb_valid && r_wb_reg == w_rt) ? r_busW : r_rf[w_rt];

  always_comb begin
    w_imm_ext = '0;
    case (w_ctrl.imm_kind)
      IMM_SEXT: w_imm_ext = XLEN'($signed(w_imm));
      IMM_ZEXT: w_imm_ext = XLEN'(w_imm);
      IMM_LUI:  w_imm_ext = XLEN'({w_imm, 16'h0000});
      default:  w_imm_ext = '0;
    endcase
  end

  assign w_opb = (w_ctrl.imm_kind == IMM_NONE) ? w_rt_val : w_imm_ext;

  exec_alu #(.XLEN(XLEN)) u_alu (
    .i_op       (w_ctrl.alu_op),
    .i_a        (w_rs_val),
    .i_b        (w_opb),
    .i_shamt    (instr[10:6]),
    .o_result_c (w_alu_res),
    .o_ovf_c    (w_alu_ovf)
  );

  // Without forwarding, hold off any instruction that reads the pending WB dest.
  assign w_hazard = !FWD_EN && r_wb_valid &&
                    ((w_ctrl.use_rs && r_wb_reg == w_rs) ||
                     (w_ctrl.use_rt && r_wb_reg == w_rt));

  assign in_ready = !RST && !stall && !w_hazard;
  assign w_accept = in_valid && in_ready;
  assign w_ovf    = w_ctrl.chk_ovf && w_alu_ovf && !w_ctrl.illegal;
  assign w_commit = !w_ctrl.illegal && !w_ovf && (w_dst != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(NREG); i++) r_rf[i] <= '0;
      r_busA     <= '0;
      r_busB     <= '0;
      r_busW     <= '0;
      r_wb_reg   <= '0;
      r_wb_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (!stall) begin
      if (r_wb_valid) r_rf[r_wb_reg] <= r_busW;
      if (w_accept) begin
        r_busA     <= w_rs_val;
        r_busB     <= w_opb;
        r_busW     <= w_alu_res;
        r_wb_reg   <= w_dst;
        r_wb_valid <= w_commit;
        r_ovf      <= w_ovf;
        r_illegal  <= w_ctrl.illegal;
      end else begin
        r_wb_valid <= 1'b0;
        r_ovf      <= 1'b0;
        r_illegal  <= 1'b0;
      end
    end else begin
      // Stalled: pipeline held, but status pulses must not stretch.
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
    end
  end

  assign busA     = r_busA;
  assign busB     = r_busB;
  assign busW     = r_busW;
  assign wb_reg   = r_wb_reg;
  assign wb_valid = r_wb_valid;
  assign ovf      = r_ovf;
  assign illegal  = r_illegal;
  assign dbg_data = r_rf[dbg_sel];

endmodule
